// File: rtl/ts_failover_selector_pkg.sv
// Shared types and helpers for the TS failover selector: FSM states and
// the priority-list resolver used to pick the best healthy channel.
package ts_failover_selector_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKED  = 2'd1,
      PENDING = 2'd2
   } sel_state_t;

   localparam logic [7:0] SYNC_BYTE  = 8'h47;
   localparam int         TS_PKT_LEN = 188;

   typedef struct packed {
      logic       found;
      logic [4:0] rank;
      logic [3:0] ch;
   } best_t;

   // Lists are zero-extended to 16 channels x 4 bits; scanning from the
   // bottom rank upwards leaves the lowest healthy rank as the result.
   function automatic best_t best_rank(input logic [63:0] prio,
                                       input logic [15:0] healthy,
                                       input int num_ch,
                                       input int ch_w);
      best_t      b;
      logic [3:0] c;
      b = '0;
      for (int r = 15; r >= 0; r--) begin
         if (r < num_ch) begin
            c = 4'((prio >> (r * ch_w)) & ((64'd1 << ch_w) - 64'd1));
            if (healthy[c]) begin
               b.found = 1'b1;
               b.rank  = 5'(r);
               b.ch    = c;
            end
         end
      end
      return b;
   endfunction

   // First-occurrence rank of a channel; 16 means it is not in the list.
   function automatic logic [4:0] rank_of(input logic [63:0] prio,
                                          input logic [3:0] ch,
                                          input int num_ch,
                                          input int ch_w);
      logic [4:0] rk;
      rk = 5'd16;
      for (int r = 15; r >= 0; r--) begin
         if (r < num_ch) begin
            if (4'((prio >> (r * ch_w)) & ((64'd1 << ch_w) - 64'd1)) == ch)
               rk = 5'(r);
         end
      end
      return rk;
   endfunction

endpackage

// File: rtl/ts_failover_selector_health.sv
// Per-channel health tracker: holdoff quarantine timer, healthy flag and a
// saturating error counter.
module ts_ch_health
   import ts_failover_selector_pkg::*;
#(
   parameter int TIMER_W  = 20,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                present,
   input  logic                err,
   input  logic                err_clear,
   input  logic [TIMER_W-1:0]  holdoff,
   output logic                healthy,
   output logic [ERRCNT_W-1:0] err_count
);

   logic [TIMER_W-1:0] timer;

   // A bad cycle restarts the quarantine; healthy rises the cycle after the
   // timer has drained, so holdoff=0 gives a plain one-cycle registered view.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= holdoff;
         healthy <= 1'b0;
      end else if (err || !present) begin
         timer   <= holdoff;
         healthy <= 1'b0;
      end else if (timer != '0) begin
         timer <= timer - 1'b1;
      end else begin
         healthy <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || err_clear)
         err_count <= '0;
      else if (err && !(&err_count))
         err_count <= err_count + 1'b1;
   end

endmodule

// File: rtl/ts_failover_selector.sv
// Chooses which TS input drives the output mux, failing over between
// channels only on output packet boundaries (or after a bounded wait).
module ts_failover_selector
   import ts_failover_selector_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int TIMER_W  = 20,
   parameter int ERRCNT_W = 8,
   parameter int PEND_MAX = 1024,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_present,
   input  logic [NUM_CH-1:0]          ch_err,
   input  logic                       pkt_boundary,
   input  logic                       cfg_fallback_en,
   input  logic                       cfg_manual_en,
   input  logic [CH_W-1:0]            cfg_manual_ch,
   input  logic                       cfg_revert_en,
   input  logic [NUM_CH*CH_W-1:0]     cfg_priority,
   input  logic [TIMER_W-1:0]         cfg_holdoff,
   input  logic                       cfg_err_clear,
   output logic [CH_W-1:0]            active_ch,
   output logic                       out_enable,
   output logic                       switch_evt,
   output logic [NUM_CH-1:0]          ch_healthy,
   output logic [NUM_CH*ERRCNT_W-1:0] err_count,
   output logic [1:0]                 sel_state
);

   localparam int PEND_W = $clog2(PEND_MAX);
   localparam logic [PEND_W-1:0] PEND_LAST = PEND_W'(PEND_MAX - 1);

   sel_state_t        state;
   logic [PEND_W-1:0] pend_cnt;
   logic [63:0]       prio_ext;
   logic [15:0]       healthy_ext;
   best_t             best;
   logic [CH_W-1:0]   best_ch;
   logic [4:0]        active_rank;
   logic              active_healthy;
   logic              auto_fail;
   logic              need_switch;
   logic [CH_W-1:0]   target;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_health
      ts_ch_health #(
         .TIMER_W  (TIMER_W),
         .ERRCNT_W (ERRCNT_W)
      ) u_health (
         .clk       (clk),
         .rst       (rst),
         .present   (ch_present[i]),
         .err       (ch_err[i]),
         .err_clear (cfg_err_clear),
         .holdoff   (cfg_holdoff),
         .healthy   (ch_healthy[i]),
         .err_count (err_count[i*ERRCNT_W +: ERRCNT_W])
      );
   end

   assign prio_ext       = 64'(cfg_priority);
   assign healthy_ext    = 16'(ch_healthy);
   assign best           = best_rank(prio_ext, healthy_ext, NUM_CH, CH_W);
   assign best_ch        = best.ch[CH_W-1:0];
   assign active_rank    = rank_of(prio_ext, 4'(active_ch), NUM_CH, CH_W);
   assign active_healthy = healthy_ext[4'(active_ch)];
   assign auto_fail      = !cfg_manual_en && cfg_fallback_en && !active_healthy;

   // A locked selector only moves when manual asks for another channel or
   // auto failover/revert finds a better healthy one.
   always_comb begin
      target      = active_ch;
      need_switch = 1'b0;
      if (cfg_manual_en) begin
         target      = cfg_manual_ch;
         need_switch = (cfg_manual_ch != active_ch);
      end else if (cfg_fallback_en && best.found) begin
         target      = best_ch;
         need_switch = !active_healthy ||
                       (cfg_revert_en && (best.rank < active_rank));
      end
   end

   assign sel_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEARCH;
         active_ch  <= cfg_priority[CH_W-1:0];
         out_enable <= 1'b0;
         switch_evt <= 1'b0;
         pend_cnt   <= '0;
      end else begin
         switch_evt <= 1'b0;
         case (state)
            SEARCH: begin
               if (cfg_manual_en || best.found) begin
                  active_ch  <= target;
                  switch_evt <= (target != active_ch);
                  state      <= LOCKED;
                  out_enable <= 1'b1;
               end
            end
            LOCKED: begin
               if (auto_fail && !best.found) begin
                  state      <= SEARCH;
                  out_enable <= 1'b0;
               end else if (need_switch) begin
                  if (pkt_boundary) begin
                     active_ch  <= target;
                     switch_evt <= 1'b1;
                  end else begin
                     state    <= PENDING;
                     pend_cnt <= '0;
                  end
               end
            end
            PENDING: begin
               if (!cfg_manual_en && cfg_fallback_en && !best.found) begin
                  state      <= SEARCH;
                  out_enable <= 1'b0;
               end else if (target == active_ch) begin
                  state <= LOCKED;
               end else if (pkt_boundary || pend_cnt == PEND_LAST) begin
                  active_ch  <= target;
                  switch_evt <= 1'b1;
                  state      <= LOCKED;
               end else begin
                  pend_cnt <= pend_cnt + 1'b1;
               end
            end
            default: begin
               state      <= SEARCH;
               out_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule
